game_sequencer: RTL and testbench

- Parametrised second-generation top-level Tetris control FSM.
- Sits between the PS/2 keycode path and the playfield datapath. Issues one 3-bit command per cycle: check, gravity step, write, shift, spawn, lateral window.
- Additions over the first generation: configurable row count, level-scaled gravity period, line/level counters, edge-qualified keys, restart from game over.

---
 rtl/game_sequencer_if.sv | 37 +++
 rtl/game_sequencer.sv | 177 +++++++++++++++++
 tb/tb_game_sequencer.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/game_sequencer_if.sv
// Port bundle between the Tetris control sequencer and its playfield datapath.
// The paused signal exists only when GAME_SEQUENCER_PAUSE_EN is defined.
interface game_sequencer_if #(
   parameter int ROWS  = 22,
   parameter int LVL_W = 4
);
   logic [7:0]       keycode;
   logic             can_rotate;
   logic             can_swap;
   logic [ROWS-1:0]  stop;
   logic [ROWS-1:0]  full_rows;
   logic             game_over;
   logic             startscreen;
   logic [2:0]       cmd;
   logic [ROWS-1:0]  shift_row;
   logic [LVL_W-1:0] level;
   logic [15:0]      lines;
`ifdef GAME_SEQUENCER_PAUSE_EN
   logic             paused;
`endif

   modport slave (
      input  keycode, can_rotate, can_swap, stop, full_rows, game_over,
      output startscreen, cmd, shift_row, level, lines
`ifdef GAME_SEQUENCER_PAUSE_EN
      , paused
`endif
   );

   modport master (
      output keycode, can_rotate, can_swap, stop, full_rows, game_over,
      input  startscreen, cmd, shift_row, level, lines
`ifdef GAME_SEQUENCER_PAUSE_EN
      , paused
`endif
   );
endinterface

// File: rtl/game_sequencer.sv
// Top-level Tetris control FSM: one datapath command per cycle, level-scaled gravity,
// line/level counters and restart. Define GAME_SEQUENCER_PAUSE_EN to add the PAUSE state.
//
// state  | meaning
// IDLE   | start screen, wait for Enter edge
// CHECK  | look for a full row, first sample
// CHECK2 | look for a full row, second sample; none -> spawn
// SHIFT  | delete the latched row, bump line/level counters
// SPAWN  | spawn command, first cycle
// SPAWN2 | spawn command, second cycle
// FALL   | piece in play: gravity timer and lateral window
// WRITE  | piece landed, settle cycle
// WRITE2 | write piece into playfield
// HALT   | game over, wait for Enter edge
// PAUSE  | gravity frozen (optional)
module game_sequencer #(
   parameter int ROWS            = 22,
   parameter int CNT_W           = 24,
   parameter int BASE_PERIOD     = 1_000_000,
   parameter int PERIOD_STEP     = 60_000,
   parameter int MIN_PERIOD      = 100_000,
   parameter int LINES_PER_LEVEL = 10,
   parameter int LVL_W           = 4
) (
   input  logic             clk_i,
   input  logic             reset_ni,
   game_sequencer_if.slave  bus
);
   localparam int PW  = CNT_W + LVL_W;
   localparam int LCW = (LINES_PER_LEVEL < 2) ? 1 : $clog2(LINES_PER_LEVEL + 1);

   localparam logic [7:0] KEY_ENTER  = 8'h28;
   localparam logic [7:0] KEY_ROTATE = 8'h1A;
   localparam logic [7:0] KEY_SWAP   = 8'h06;

   typedef enum logic [3:0] {
      S_IDLE   = 4'd0,
      S_CHECK  = 4'd1,
      S_CHECK2 = 4'd2,
      S_SHIFT  = 4'd3,
      S_SPAWN  = 4'd4,
      S_SPAWN2 = 4'd5,
      S_FALL   = 4'd6,
      S_WRITE  = 4'd7,
      S_WRITE2 = 4'd8,
      S_HALT   = 4'd9
`ifdef GAME_SEQUENCER_PAUSE_EN
      , S_PAUSE = 4'd10
`endif
   } state_t;

   state_t           state_q;
   logic [7:0]       key_prev_q;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] period_q;
   logic [CNT_W-1:0] period_d;
   logic [ROWS-1:0]  shift_row_q;
   logic [LVL_W-1:0] level_q;
   logic [LCW-1:0]   lvl_cnt_q;
   logic [15:0]      lines_q;
   logic [PW-1:0]    step_prod;
   logic [PW-1:0]    base_ext;
   logic [ROWS-1:0]  lowest_d;
   logic [2:0]       cmd_d;

   logic key_new, enter_edge, rot_edge, swap_edge, grav_tick;

   assign key_new    = (bus.keycode != key_prev_q);
   assign enter_edge = key_new && (bus.keycode == KEY_ENTER);
   assign rot_edge   = key_new && (bus.keycode == KEY_ROTATE) && bus.can_rotate;
   assign swap_edge  = key_new && (bus.keycode == KEY_SWAP) && bus.can_swap;
   assign grav_tick  = (cnt_q == period_q - CNT_W'(1));

`ifdef GAME_SEQUENCER_PAUSE_EN
   logic pause_edge;
   assign pause_edge = key_new && (bus.keycode == 8'h13);
   assign bus.paused = (state_q == S_PAUSE);
`endif

   // Two's-complement trick isolates the lowest set bit, so rows clear bottom-index first.
   assign lowest_d = bus.full_rows & (~bus.full_rows + ROWS'(1));

   always_comb begin
      base_ext  = PW'(BASE_PERIOD);
      step_prod = PW'(level_q) * PW'(PERIOD_STEP);
      if ((step_prod > base_ext) || ((base_ext - step_prod) < PW'(MIN_PERIOD)))
         period_d = CNT_W'(MIN_PERIOD);
      else
         period_d = CNT_W'(base_ext - step_prod);
   end

   always_comb begin
      cmd_d = 3'b000;
      case (state_q)
         S_SHIFT:           cmd_d = 3'b011;
         S_SPAWN, S_SPAWN2: cmd_d = 3'b100;
         S_FALL:            cmd_d = grav_tick ? 3'b001 : 3'b111;
         S_WRITE2:          cmd_d = 3'b010;
         default:           cmd_d = 3'b000;
      endcase
   end

   assign bus.cmd         = cmd_d;
   assign bus.startscreen = (state_q == S_IDLE);
   assign bus.shift_row   = shift_row_q;
   assign bus.level       = level_q;
   assign bus.lines       = lines_q;

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_q     <= S_IDLE;
         key_prev_q  <= 8'h00;
         cnt_q       <= '0;
         period_q    <= CNT_W'(BASE_PERIOD);
         shift_row_q <= '0;
         level_q     <= '0;
         lvl_cnt_q   <= '0;
         lines_q     <= '0;
      end else begin
         key_prev_q <= bus.keycode;
         // Level only moves while the counter is parked at zero, so a new period is safe.
         period_q   <= period_d;
         case (state_q)
            S_IDLE: if (enter_edge) state_q <= S_CHECK;
            S_CHECK, S_CHECK2: begin
               if (|bus.full_rows) begin
                  shift_row_q <= lowest_d;
                  state_q     <= S_SHIFT;
               end else begin
                  state_q <= (state_q == S_CHECK) ? S_CHECK2 : S_SPAWN;
               end
            end
            S_SHIFT: begin
               if (lines_q != 16'hFFFF) lines_q <= lines_q + 16'd1;
               if (lvl_cnt_q + LCW'(1) == LCW'(LINES_PER_LEVEL)) begin
                  lvl_cnt_q <= '0;
                  if (level_q != '1) level_q <= level_q + LVL_W'(1);
               end else begin
                  lvl_cnt_q <= lvl_cnt_q + LCW'(1);
               end
               state_q <= S_CHECK;
            end
            S_SPAWN:  state_q <= bus.game_over ? S_HALT : S_SPAWN2;
            S_SPAWN2: state_q <= bus.game_over ? S_HALT : S_FALL;
            S_FALL: begin
               if (|bus.stop) begin
                  cnt_q   <= '0;
                  state_q <= S_WRITE;
               end else if (grav_tick) begin
                  cnt_q <= '0;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
                  if (rot_edge || swap_edge) state_q <= S_SPAWN;
`ifdef GAME_SEQUENCER_PAUSE_EN
                  else if (pause_edge) state_q <= S_PAUSE;
`endif
               end
            end
            S_WRITE:  state_q <= bus.game_over ? S_HALT : S_WRITE2;
            S_WRITE2: state_q <= bus.game_over ? S_HALT : S_CHECK;
            S_HALT: begin
               if (enter_edge) begin
                  lines_q     <= '0;
                  level_q     <= '0;
                  lvl_cnt_q   <= '0;
                  shift_row_q <= '0;
                  state_q     <= S_IDLE;
               end
            end
`ifdef GAME_SEQUENCER_PAUSE_EN
            S_PAUSE: if (pause_edge) state_q <= S_FALL;
`endif
            default: state_q <= S_CHECK;
         endcase
      end
   end
endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer with a small-period configuration; expected
// outputs are queued as stimulus is applied and compared after the following clock edge.
module tb_game_sequencer;
   localparam int ROWS = 22;

   localparam int SEL_CMD   = 0;
   localparam int SEL_SS    = 1;
   localparam int SEL_ROW   = 2;
   localparam int SEL_LVL   = 3;
   localparam int SEL_LINES = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   game_sequencer_if #(.ROWS(ROWS), .LVL_W(4)) bus ();

   game_sequencer #(
      .ROWS(ROWS), .CNT_W(24), .BASE_PERIOD(8), .PERIOD_STEP(3),
      .MIN_PERIOD(4), .LINES_PER_LEVEL(2), .LVL_W(4)
   ) dut (
      .clk_i   (clk),
      .reset_ni(rst_n),
      .bus     (bus)
   );

   typedef struct {
      string       tag;
      int          sel;
      logic [31:0] exp;
   } exp_t;

   exp_t sb[$];
   int   total  = 0;
   int   passed = 0;
   int   fails  = 0;

   function automatic logic [31:0] observe(int sel);
      case (sel)
         SEL_CMD:   return 32'(bus.cmd);
         SEL_SS:    return 32'(bus.startscreen);
         SEL_ROW:   return 32'(bus.shift_row);
         SEL_LVL:   return 32'(bus.level);
         SEL_LINES: return 32'(bus.lines);
         default:   return 32'hDEAD_BEEF;
      endcase
   endfunction

   task automatic chk(string tag, logic [31:0] o, logic [31:0] e);
      total++;
      assert (o === e) passed++;
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, o, e);
      end
   endtask

   task automatic expect_val(string tag, int sel, logic [31:0] e);
      exp_t x;
      x.tag = tag;
      x.sel = sel;
      x.exp = e;
      sb.push_back(x);
   endtask

   task automatic drain();
      exp_t x;
      while (sb.size() != 0) begin
         x = sb.pop_front();
         chk(x.tag, observe(x.sel), x.exp);
      end
   endtask

   task automatic cyc();
      @(negedge clk);
      drain();
   endtask

   task automatic step_cmd(string tag, logic [2:0] c);
      expect_val(tag, SEL_CMD, 32'(c));
      cyc();
   endtask

   task automatic gravity(int n, int period);
      for (int i = 0; i < n; i++)
         step_cmd("gravity", (i % period == period - 1) ? 3'b001 : 3'b111);
   endtask

   task automatic land_and_clear(logic [ROWS-1:0] r1, logic [ROWS-1:0] r2,
                                 logic [15:0] exp_lines, logic [3:0] exp_level);
      bus.stop      = 22'h1;
      bus.full_rows = r1 | r2;
      step_cmd("write", 3'b000);
      bus.stop = '0;
      step_cmd("write2", 3'b010);
      step_cmd("check_a", 3'b000);
      expect_val("shift_row_first", SEL_ROW, 32'(r1));
      step_cmd("shift_first", 3'b011);
      bus.full_rows = r2;
      expect_val("lines_mid", SEL_LINES, 32'(exp_lines - 16'd1));
      step_cmd("check_b", 3'b000);
      expect_val("shift_row_second", SEL_ROW, 32'(r2));
      step_cmd("shift_second", 3'b011);
      bus.full_rows = '0;
      expect_val("lines_after", SEL_LINES, 32'(exp_lines));
      expect_val("level_after", SEL_LVL, 32'(exp_level));
      step_cmd("check_c", 3'b000);
      step_cmd("check2", 3'b000);
      step_cmd("spawn", 3'b100);
      step_cmd("spawn2", 3'b100);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int spawn_cnt;
      bus.keycode    = 8'h00;
      bus.can_rotate = 1'b0;
      bus.can_swap   = 1'b0;
      bus.stop       = '0;
      bus.full_rows  = '0;
      bus.game_over  = 1'b0;

      repeat (2) @(negedge clk);
      expect_val("rst_startscreen", SEL_SS, 32'd1);
      expect_val("rst_cmd", SEL_CMD, 32'd0);
      expect_val("rst_shift_row", SEL_ROW, 32'd0);
      expect_val("rst_level", SEL_LVL, 32'd0);
      expect_val("rst_lines", SEL_LINES, 32'd0);
      drain();
      rst_n = 1'b1;

      for (int i = 0; i < 10; i++) begin
         expect_val("idle_startscreen", SEL_SS, 32'd1);
         step_cmd("idle_cmd", 3'b000);
      end

      bus.keycode = 8'h28;
      expect_val("enter_leaves_idle", SEL_SS, 32'd0);
      step_cmd("enter_check", 3'b000);
      bus.keycode = 8'h00;
      step_cmd("check2", 3'b000);
      step_cmd("spawn", 3'b100);
      step_cmd("spawn2", 3'b100);

      gravity(24, 8);
      land_and_clear(22'h000004, 22'h000020, 16'd2, 4'd1);
      gravity(15, 5);
      land_and_clear(22'h000001, 22'h000002, 16'd4, 4'd2);
      gravity(15, 4);

      // Gravity tick coincides with stop: tick command shown, then WRITE.
      step_cmd("tick_with_stop", 3'b001);
      bus.stop = 22'h100;
      step_cmd("stop_wins", 3'b000);
      bus.stop = '0;
      step_cmd("write2_b", 3'b010);
      step_cmd("check_d", 3'b000);
      step_cmd("check2_d", 3'b000);
      step_cmd("spawn_d", 3'b100);
      step_cmd("spawn2_d", 3'b100);
      gravity(4, 4);
      step_cmd("pre_rotate", 3'b111);

      bus.keycode    = 8'h1A;
      bus.can_rotate = 1'b1;
      spawn_cnt = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (bus.cmd == 3'b100) spawn_cnt++;
      end
      chk("held_rotate_spawn_cycles", 32'(spawn_cnt), 32'd2);

      bus.keycode = 8'h00;
      step_cmd("release_tick", 3'b001);
      step_cmd("release_idle", 3'b111);
      bus.keycode = 8'h1A;
      step_cmd("repress_spawn", 3'b100);

      bus.game_over = 1'b1;
      expect_val("halt_startscreen", SEL_SS, 32'd0);
      expect_val("halt_lines_kept", SEL_LINES, 32'd4);
      step_cmd("game_over_halt", 3'b000);
      bus.game_over = 1'b0;
      step_cmd("halt_hold", 3'b000);

      bus.keycode = 8'h28;
      expect_val("restart_startscreen", SEL_SS, 32'd1);
      expect_val("restart_lines", SEL_LINES, 32'd0);
      expect_val("restart_level", SEL_LVL, 32'd0);
      expect_val("restart_shift_row", SEL_ROW, 32'd0);
      step_cmd("restart_cmd", 3'b000);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
